// File: rtl/wb_mux_pkg.sv
// Shared definitions for the Wishbone N-way slave mux.
// Holds the FSM state encoding, the bus address width and the data word
// returned to the master when an external-ack slave times out.
package wb_mux_pkg;

    localparam int unsigned ADR_W = 32;

    localparam logic [ADR_W-1:0] TO_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/wb_mux_decode.sv
// Slave decode for wb_mux_n: picks the slave index from the upper address
// bits and raises the matching per-slave cyc line.
// Ports:
//   adr      master address (only the top SEL_W bits select the slave)
//   cyc      master cycle
//   busy     high while the mux is presenting its ack; masks all slave cyc
//   idx_c    decoded slave index
//   cyc_oh_c one-hot per-slave cyc
module wb_mux_decode
    import wb_mux_pkg::*;
#(
    parameter int unsigned SEL_W = 2
) (
    input  logic [ADR_W-1:0]        adr,
    input  logic                    cyc,
    input  logic                    busy,
    output logic [SEL_W-1:0]        idx_c,
    output logic [(2**SEL_W)-1:0]   cyc_oh_c
);

    localparam int unsigned NSLV = 2**SEL_W;

    // Lower address bits only pass through to the slaves, not the decode.
    logic unused_adr;
    assign unused_adr = ^adr[ADR_W-SEL_W-1:0];

    assign idx_c = adr[ADR_W-1 -: SEL_W];

    // One-hot cyc toward the addressed slave.
    always_comb begin
        cyc_oh_c = '0;
        for (int k = 0; k < NSLV; k++) begin
            cyc_oh_c[k] = cyc && !busy && (idx_c == SEL_W'(k));
        end
    end

endmodule

// File: rtl/wb_mux_n.sv
// Wishbone 1-master to 2**SEL_W-slave mux with per-slave ack mode.
// Slaves flagged in EXT_ACK supply their own ack; all others are acked by
// the mux one cycle after the access is seen. Ack and read data to the
// master are registered. A master must release cyc after an ack before a
// new access is accepted, so a held cyc never produces a second ack.
// Optional feature: define WB_MUX_TIMEOUT_EN to bound external-ack waits to
// TO_CYC cycles; a timeout acks with TO_DATA and sets the sticky o_err.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wb_cpu_*                   master request (adr, dat, sel, we, cyc)
//   o_wb_cpu_rdt, o_wb_cpu_ack   registered response to the master
//   o_wb_s_*                     broadcast request, one-hot cyc per slave
//   i_wb_s_rdt, i_wb_s_ack       per-slave response
//   o_err, i_err_clr             sticky timeout flag and its clear
module wb_mux_n
    import wb_mux_pkg::*;
#(
    parameter int unsigned             SEL_W   = 2,
    parameter logic [(2**SEL_W)-1:0]   EXT_ACK = 'b0010,
    parameter int unsigned             TO_CYC  = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [ADR_W-1:0]              i_wb_cpu_adr,
    input  logic [ADR_W-1:0]              i_wb_cpu_dat,
    input  logic [3:0]                    i_wb_cpu_sel,
    input  logic                          i_wb_cpu_we,
    input  logic                          i_wb_cpu_cyc,
    output logic [ADR_W-1:0]              o_wb_cpu_rdt,
    output logic                          o_wb_cpu_ack,
    output logic [(2**SEL_W)*ADR_W-1:0]   o_wb_s_adr,
    output logic [(2**SEL_W)*ADR_W-1:0]   o_wb_s_dat,
    output logic [(2**SEL_W)*4-1:0]       o_wb_s_sel,
    output logic [(2**SEL_W)-1:0]         o_wb_s_we,
    output logic [(2**SEL_W)-1:0]         o_wb_s_cyc,
    input  logic [(2**SEL_W)*ADR_W-1:0]   i_wb_s_rdt,
    input  logic [(2**SEL_W)-1:0]         i_wb_s_ack,
    output logic                          o_err,
    input  logic                          i_err_clr
);

    localparam int unsigned NSLV = 2**SEL_W;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx;
    logic [SEL_W-1:0]     widx_q, widx_d;
    logic                 ack_q, ack_d;
    logic [ADR_W-1:0]     rdt_q, rdt_d;
    logic                 hold_q, hold_d;
    logic [ADR_W-1:0]     s_rdt [NSLV];

    // Request fields go to every slave unchanged.
    assign o_wb_s_adr = {NSLV{i_wb_cpu_adr}};
    assign o_wb_s_dat = {NSLV{i_wb_cpu_dat}};
    assign o_wb_s_sel = {NSLV{i_wb_cpu_sel}};
    assign o_wb_s_we  = {NSLV{i_wb_cpu_we}};

    for (genvar g = 0; g < NSLV; g++) begin : g_rdt
        assign s_rdt[g] = i_wb_s_rdt[g*ADR_W +: ADR_W];
    end

    wb_mux_decode #(.SEL_W(SEL_W)) u_decode (
        .adr      (i_wb_cpu_adr),
        .cyc      (i_wb_cpu_cyc),
        .busy     (state_q == ACK),
        .idx_c    (idx),
        .cyc_oh_c (o_wb_s_cyc)
    );

`ifdef WB_MUX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TO_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
`endif

    // Next-state, ack and read-data capture.
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        ack_d   = 1'b0;
        rdt_d   = rdt_q;
`ifdef WB_MUX_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = i_err_clr ? 1'b0 : err_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_wb_cpu_cyc && !hold_q) begin
                    if (!EXT_ACK[idx] || i_wb_s_ack[idx]) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        rdt_d   = s_rdt[idx];
                    end else begin
                        state_d = WAIT;
                        widx_d  = idx;
`ifdef WB_MUX_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            WAIT: begin
                if (!i_wb_cpu_cyc) begin
                    state_d = IDLE;
`ifdef WB_MUX_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (i_wb_s_ack[widx_q]) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    rdt_d   = s_rdt[widx_q];
`ifdef WB_MUX_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TO_CYC)) begin
                    // Timeout set takes priority over a same-cycle clear.
                    state_d = ACK;
                    ack_d   = 1'b1;
                    rdt_d   = TO_DATA;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Block re-entry until the master drops cyc after its ack.
        if (!i_wb_cpu_cyc) begin
            hold_d = 1'b0;
        end else if (ack_d) begin
            hold_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end
    end

    // State and response registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            widx_q  <= '0;
            ack_q   <= 1'b0;
            rdt_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            ack_q   <= ack_d;
            rdt_q   <= rdt_d;
            hold_q  <= hold_d;
        end
    end

`ifdef WB_MUX_TIMEOUT_EN
    // Wait counter and sticky timeout flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_wb_cpu_ack = ack_q;
    assign o_wb_cpu_rdt = rdt_q;

endmodule

// File: doc/wb_mux_n.md
WB_MUX_N -- requirements
Module: wb_mux_n

Interface
REQ-001 Parameter SEL_W, default 2, number of upper address bits used for slave decode; slave count NSLV = 2**SEL_W.
REQ-002 Parameter EXT_ACK, NSLV bits, default 'b0010; bit k=1 means slave k supplies its own ack, bit k=0 means the mux generates a fixed one-cycle ack.
REQ-003 Parameter TO_CYC, default 255, wait-state limit for external-ack slaves (used only with the timeout feature).
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_wb_cpu_adr/i_wb_cpu_dat  in  32 each  master address / write data.
REQ-007 i_wb_cpu_sel  in  4, i_wb_cpu_we  in  1, i_wb_cpu_cyc  in  1  master byte select, write enable, cycle.
REQ-008 o_wb_cpu_rdt  out  32  registered read data; o_wb_cpu_ack  out  1  registered ack.
REQ-009 o_wb_s_adr/o_wb_s_dat  out  NSLV*32  per-slave address/data, slice k = bits [32k+31:32k].
REQ-010 o_wb_s_sel  out  NSLV*4; o_wb_s_we  out  NSLV; o_wb_s_cyc  out  NSLV  per-slave select, we, cycle.
REQ-011 i_wb_s_rdt  in  NSLV*32; i_wb_s_ack  in  NSLV  per-slave read data and ack (ack ignored where EXT_ACK bit is 0).
REQ-012 o_err  out  1  sticky timeout flag; i_err_clr  in  1  clears o_err.

Function
REQ-013 Slave index k = i_wb_cpu_adr[31:32-SEL_W]; adr, dat, sel, we broadcast unmodified to every slave slice.
REQ-014 o_wb_s_cyc[k] = i_wb_cpu_cyc & (decoded index == k) & (state != ACK); all other cyc bits 0.
REQ-015 FSM states IDLE, WAIT, ACK; reset state IDLE.
REQ-016 IDLE, cyc=1, EXT_ACK[k]=0: next state ACK; o_wb_cpu_ack=1 one cycle after cyc first seen (1-cycle latency); o_wb_cpu_rdt captures slice k of i_wb_s_rdt at that edge.
REQ-017 IDLE, cyc=1, EXT_ACK[k]=1: if i_wb_s_ack[k]=1 same cycle, go to ACK as REQ-016; else go to WAIT and latch k.
REQ-018 WAIT: on i_wb_s_ack[latched k]=1 go to ACK, capturing that slave's rdt; ack therefore lags slave ack by exactly one cycle.
REQ-019 WAIT, cyc drops to 0: return to IDLE, no ack, counter cleared.
REQ-020 ACK: o_wb_cpu_ack=1 for exactly one cycle, then IDLE unconditionally; back-to-back ack never occurs (min two cycles between acks).
REQ-021 o_wb_cpu_rdt holds last captured value while ack=0; writes also capture (value don't-care to master).
REQ-022 Wait counter width clog2(TO_CYC+1); cleared on entry to WAIT; saturates, never wraps.

Reset
REQ-023 On i_rst=1 at a rising edge: state IDLE, o_wb_cpu_ack=0, o_wb_cpu_rdt=0, counter=0, o_err=0; i_rst overrides every other event that cycle including a pending slave ack.
REQ-024 Reset mid-WAIT aborts the transfer; no ack is issued for it afterwards.

Configuration
REQ-025 Macro WB_MUX_TIMEOUT_EN defined: when counter reaches TO_CYC in WAIT, go to ACK with rdt=32'hDEADBEEF and set o_err; i_err_clr clears o_err next edge; timeout set wins over simultaneous clear.
REQ-026 Macro undefined: WAIT persists until slave ack or cyc drop; counter not built; o_err tied 0; i_err_clr unused.

Structure
REQ-027 Shared package wb_mux_pkg holds state enum (IDLE/WAIT/ACK), timeout data constant 32'hDEADBEEF, and address width 32.
REQ-028 One sub-module wb_mux_decode: combinational index decode and one-hot cyc generation; FSM, counter and rdt register stay in top.

Verification
REQ-029 SEL_W=2, read adr 0x0000_0010, slave0 rdt 0x1234_5678 -> ack 1 cycle after cyc, rdt 0x1234_5678, only o_wb_s_cyc[0] high.
REQ-030 Read adr 0x4000_0000, slave1 acks 3 cycles after cyc with 0xCAFE_F00D -> ack 4 cycles after cyc, rdt 0xCAFE_F00D, cyc[1] low during ack cycle.
REQ-031 Write adr 0xC000_0004 dat 0xA5, cyc held 4 cycles -> single ack pulse at cycle 1, none at cycle 3.
REQ-032 Slave1 in WAIT, i_rst pulsed, then slave1 acks -> no cpu ack, rdt=0, state IDLE.
REQ-033 WB_MUX_TIMEOUT_EN, TO_CYC=8, slave1 never acks -> ack after TO_CYC wait cycles, rdt 0xDEADBEEF, o_err=1 until i_err_clr.
REQ-034 Slave1 in WAIT, cyc dropped for 1 cycle then new access to slave0 -> no stale ack, slave0 acked in 1 cycle.
